// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: encodings, FSM states,
// ALU operations and the instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef enum logic [1:0] {SRC_REG, SRC_SIMM, SRC_ZIMM} src_t;

  typedef struct packed {
    logic    valid;
    alu_op_t op;
    src_t    src;
    logic    wr_en;
    logic    wr_rt;
    logic    is_lw;
    logic    is_sw;
    logic    is_beq;
    logic    is_bne;
    logic    is_j;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    c.valid = 1'b1;
    c.op    = ALU_ADD;
    c.src   = SRC_REG;
    case (opcode)
      OP_RTYPE: begin
        c.wr_en = 1'b1;
        case (funct)
          FN_ADD:  c.op = ALU_ADD;
          FN_SUB:  c.op = ALU_SUB;
          FN_AND:  c.op = ALU_AND;
          FN_OR:   c.op = ALU_OR;
          FN_XOR:  c.op = ALU_XOR;
          FN_NOR:  c.op = ALU_NOR;
          FN_SLT:  c.op = ALU_SLT;
          FN_SLL:  c.op = ALU_SLL;
          FN_SRL:  c.op = ALU_SRL;
          default: c.valid = 1'b0;
        endcase
      end
      OP_ADDI: begin c.src = SRC_SIMM; c.wr_en = 1'b1; c.wr_rt = 1'b1; end
      OP_SLTI: begin c.op = ALU_SLT; c.src = SRC_SIMM; c.wr_en = 1'b1; c.wr_rt = 1'b1; end
      OP_ANDI: begin c.op = ALU_AND; c.src = SRC_ZIMM; c.wr_en = 1'b1; c.wr_rt = 1'b1; end
      OP_ORI:  begin c.op = ALU_OR;  c.src = SRC_ZIMM; c.wr_en = 1'b1; c.wr_rt = 1'b1; end
      OP_LW:   begin c.src = SRC_SIMM; c.wr_en = 1'b1; c.wr_rt = 1'b1; c.is_lw = 1'b1; end
      OP_SW:   begin c.src = SRC_SIMM; c.is_sw = 1'b1; end
      OP_BEQ:  begin c.op = ALU_SUB; c.is_beq = 1'b1; end
      OP_BNE:  begin c.op = ALU_SUB; c.is_bne = 1'b1; end
      OP_J:    c.is_j = 1'b1;
      default: c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: two's-complement arithmetic, logic ops, signed compare
// and logical shifts of the B operand.
module mips_alu
  import mips_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  alu_op_t            op,
  input  logic        [4:0]  shamt,
  output logic signed [31:0] result,
  output logic               zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = (a < b) ? 32'sd1 : 32'sd0;
      ALU_SLL: result = $signed($unsigned(b) << shamt);
      ALU_SRL: result = $signed($unsigned(b) >> shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with handshaked
// instruction and data memories, a 32-entry register file and a debug port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_reg,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic              retire,
  output logic              halted
);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [31:0]        ir;
  logic [31:0]        rf [32];
  logic signed [31:0] a, b, simm, zimm, alu_out, mdr;
  logic signed [31:0] alu_b, alu_res;
  logic [4:0]         shamt, wr_idx;
  logic               alu_zero, take, fetch_pending;
  ctrl_t              ctrl, dec;

  assign dec = decode(ir[31:26], ir[5:0]);

  always_comb begin
    alu_b = b;
    case (ctrl.src)
      SRC_SIMM: alu_b = simm;
      SRC_ZIMM: alu_b = zimm;
      default:  alu_b = b;
    endcase
  end

  mips_alu u_alu (
    .a      (a),
    .b      (alu_b),
    .op     (ctrl.op),
    .shamt  (shamt),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Once a fetch is on the bus it must complete even if run drops.
  assign imem_req   = (state == ST_FETCH) && (run || fetch_pending);
  assign imem_addr  = pc;
  assign dmem_req   = (state == ST_MEM);
  assign dmem_we    = dmem_req && ctrl.is_sw;
  assign dmem_addr  = alu_out[ADDR_W-1:0];
  assign dmem_wdata = b;
  assign dbg_reg    = rf[dbg_sel];
  assign dbg_pc     = pc;
  assign retire     = (state == ST_WB);
  assign halted     = (state == ST_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FETCH;
      pc            <= RESET_PC;
      fetch_pending <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_req) begin
            if (imem_ready) begin
              ir            <= imem_rdata;
              pc            <= pc + ADDR_W'(1);
              fetch_pending <= 1'b0;
              state         <= ST_DECODE;
            end else begin
              fetch_pending <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          a      <= rf[ir[25:21]];
          b      <= rf[ir[20:16]];
          simm   <= {{16{ir[15]}}, ir[15:0]};
          zimm   <= {16'h0000, ir[15:0]};
          shamt  <= ir[10:6];
          ctrl   <= dec;
          wr_idx <= dec.wr_rt ? ir[20:16] : ir[15:11];
          state  <= dec.valid ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          alu_out <= alu_res;
          take    <= (ctrl.is_beq && alu_zero) || (ctrl.is_bne && !alu_zero);
          state   <= (ctrl.is_lw || ctrl.is_sw) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            mdr   <= dmem_rdata;
            state <= ST_WB;
          end
        end
        ST_WB: begin
          if (ctrl.wr_en && (wr_idx != 5'd0)) rf[wr_idx] <= ctrl.is_lw ? mdr : alu_out;
          // pc already points at the next instruction, so branches add simm directly.
          if (ctrl.is_j)  pc <= ir[ADDR_W-1:0];
          else if (take)  pc <= pc + simm[ADDR_W-1:0];
          state <= ST_FETCH;
        end
        default: state <= ST_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs with a per-retire
// scoreboard of register value, PC and retire spacing, plus reset/trap checks.
module tb_mips_multicycle_core;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, run;
  logic              imem_req, imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata, dmem_rdata;
  logic [4:0]        dbg_sel;
  logic [31:0]       dbg_reg;
  logic [ADDR_W-1:0] dbg_pc;
  logic              retire, halted;

  logic [31:0]       imem [1024];
  logic [31:0]       dmem [1024];
  logic              imem_en;
  int                dmem_delay;
  int                dcnt = 0;
  int                cyc = 0;
  int                last_cyc;
  logic [ADDR_W-1:0] wr_addr_log = '0;
  logic [31:0]       wr_data_log = '0;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string             tag;
    logic [4:0]        idx;
    logic [31:0]       val;
    int                gap;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  exp_t exp_q[$];

  mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dbg_sel    (dbg_sel),
    .dbg_reg    (dbg_reg),
    .dbg_pc     (dbg_pc),
    .retire     (retire),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign imem_ready = imem_en;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ready = dmem_req && (dcnt >= dmem_delay);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      wr_addr_log     <= dmem_addr;
      wr_data_log     <= dmem_wdata;
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int idx, input logic [31:0] val,
                      input int gap, input int pc);
    exp_t e;
    e.tag = tag;
    e.idx = 5'(idx);
    e.val = val;
    e.gap = gap;
    e.pc  = ADDR_W'(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_retire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (retire) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain;
    bit ok;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_retire(ok);
      check({e.tag, "_retire"}, 32'(ok), 32'd1);
      if (!ok) begin
        exp_q.delete();
        break;
      end
      if (e.gap > 0) check({e.tag, "_gap"}, 32'(cyc - last_cyc), 32'(e.gap));
      last_cyc = cyc;
      @(negedge clk);
      dbg_sel = e.idx;
      #1;
      check(e.tag, dbg_reg, e.val);
      check({e.tag, "_pc"}, 32'(dbg_pc), 32'(e.pc));
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; run = 1'b0; imem_en = 1'b1; dmem_delay = 2; dbg_sel = '0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;

    // Program A: arithmetic, store/load with a slow data memory, branches.
    imem[0] = enc_i(8, 0, 1, 16'hFFFB);      push("addi_r1", 1, 32'hFFFFFFFB, 0, 1);
    imem[1] = enc_r(1, 0, 2, 0, 'h2A);       push("slt_r2", 2, 32'h1, 4, 2);
    imem[2] = enc_i('h2B, 0, 1, 16'd3);      push("sw_r1", 1, 32'hFFFFFFFB, 7, 3);
    imem[3] = enc_i('h23, 0, 3, 16'd3);      push("lw_r3", 3, 32'hFFFFFFFB, 7, 4);
    imem[4] = enc_i(5, 0, 0, 16'd4);         push("bne_nt", 0, 32'h0, 4, 5);
    imem[5] = enc_i(4, 0, 0, 16'hFFFF);      push("beq_loop1", 0, 32'h0, 4, 5);
                                             push("beq_loop2", 0, 32'h0, 4, 5);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(dbg_pc), 32'd0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= imem_req; end
    check("idle_no_req", 32'(seen), 32'd0);

    run = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    last_cyc = cyc;
    drain();
    check("sw_addr", 32'(wr_addr_log), 32'd3);
    check("sw_data", wr_data_log, 32'hFFFFFFFB);

    // Stall a fetch, then reset in the middle of it.
    imem_en = 1'b0;
    @(negedge clk); #1;
    check("stall_req", 32'(imem_req), 32'd1);
    rst = 1'b1; run = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_req_drop", 32'(imem_req), 32'd0);
    check("rst_mid_pc", 32'(dbg_pc), 32'd0);
    imem_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= imem_req | retire; end
    check("late_ready_ignored", 32'(seen), 32'd0);
    check("late_ready_pc", 32'(dbg_pc), 32'd0);
    dbg_sel = 5'd1; #1;
    check("rst_clears_r1", dbg_reg, 32'h0);

    // Program B: remaining ALU ops, immediates, jump, taken bne, then trap.
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    dmem_delay = 0;
    imem[0]  = enc_i('h0D, 0, 4, 16'h8000);  push("ori_r4", 4, 32'h00008000, 0, 1);
    imem[1]  = enc_r(0, 4, 5, 4, 'h00);      push("sll_r5", 5, 32'h00080000, 4, 2);
    imem[2]  = enc_i(8, 0, 0, 16'd7);        push("addi_r0", 0, 32'h0, 4, 3);
    imem[3]  = enc_i(8, 0, 6, 16'hFFF0);     push("addi_r6", 6, 32'hFFFFFFF0, 4, 4);
    imem[4]  = enc_r(0, 6, 7, 28, 'h02);     push("srl_r7", 7, 32'h0000000F, 4, 5);
    imem[5]  = enc_r(7, 4, 8, 0, 'h22);      push("sub_r8", 8, 32'hFFFF800F, 4, 6);
    imem[6]  = enc_r(8, 6, 9, 0, 'h26);      push("xor_r9", 9, 32'h00007FFF, 4, 7);
    imem[7]  = enc_r(9, 0, 10, 0, 'h27);     push("nor_r10", 10, 32'hFFFF8000, 4, 8);
    imem[8]  = enc_r(8, 9, 11, 0, 'h24);     push("and_r11", 11, 32'h0000000F, 4, 9);
    imem[9]  = enc_r(4, 7, 12, 0, 'h25);     push("or_r12", 12, 32'h0000800F, 4, 10);
    imem[10] = enc_i('h0C, 6, 13, 16'hFF0F); push("andi_r13", 13, 32'h0000FF00, 4, 11);
    imem[11] = enc_i('h0A, 6, 14, 16'hFFF1); push("slti_r14", 14, 32'h1, 4, 12);
    imem[12] = enc_r(6, 6, 15, 0, 'h20);     push("add_r15", 15, 32'hFFFFFFE0, 4, 13);
    imem[13] = enc_j(20);                    push("j_20", 0, 32'h0, 4, 20);
    imem[20] = enc_i(5, 6, 0, 16'd2);        push("bne_taken", 0, 32'h0, 4, 23);
    imem[23] = enc_r(6, 7, 16, 0, 'h2A);     push("slt_signed", 16, 32'h1, 4, 24);
    imem[24] = 32'hFC000000;

    run = 1'b1;
    last_cyc = cyc;
    drain();

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    check("trap_halted", 32'(seen), 32'd1);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= imem_req | retire | dmem_req; end
    check("trap_quiet", 32'(seen), 32'd0);
    check("trap_still_halted", 32'(halted), 32'd1);
    check("trap_pc", 32'(dbg_pc), 32'd25);

    rst = 1'b1;
    @(negedge clk); #1;
    check("trap_rst_halted", 32'(halted), 32'd0);
    check("trap_rst_pc", 32'(dbg_pc), 32'd0);
    rst = 1'b0; run = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
